// File: rtl/fpu_defs.sv
// Shared constants and the queued result entry type for the FPU result packing stage.
package fpu_defs;

  localparam logic [7:0]  C_EXP_INF   = 8'hFF;
  localparam logic [7:0]  C_EXP_ZERO  = 8'h00;
  localparam logic [22:0] C_MANT_ZERO = 23'h0;
  localparam logic [31:0] C_QNAN      = 32'h7FC0_0000;

  localparam logic [3:0] C_FPU_ADD_CMD = 4'd0;
  localparam logic [3:0] C_FPU_SUB_CMD = 4'd1;
  localparam logic [3:0] C_FPU_MUL_CMD = 4'd2;
  localparam logic [3:0] C_FPU_F2I_CMD = 4'd3;
  localparam logic [3:0] C_FPU_I2F_CMD = 4'd4;

  localparam int unsigned C_FFLAG_NV = 4;
  localparam int unsigned C_FFLAG_DZ = 3;
  localparam int unsigned C_FFLAG_OF = 2;
  localparam int unsigned C_FFLAG_UF = 1;
  localparam int unsigned C_FFLAG_NX = 0;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  flags;
    logic        zero;
    logic        inf;
  } res_entry_t;

endpackage

// File: rtl/fpu_res_pack_fifo.sv
// Two-entry result queue with push/pop/flush; a flush empties it on the next edge.
module fpu_res_fifo
  import fpu_defs::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_push,
  input  logic       i_pop,
  input  logic       i_flush,
  input  res_entry_t i_data,
  output res_entry_t o_data,
  output logic [1:0] o_count
);

  res_entry_t r_mem [2];
  logic       r_rd_ptr;
  logic       r_wr_ptr;
  logic [1:0] r_count;
  logic       w_push;
  logic       w_pop;

  // Guard against push-when-full and pop-when-empty regardless of the caller.
  assign w_push = i_push & (r_count != 2'd2);
  assign w_pop  = i_pop & (r_count != 2'd0);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push && !i_rst && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/fpu_res_pack.sv
// FPU result packing stage: assembles the IEEE word, queues it, keeps sticky fflags.
// Optional exception-op counter enabled by FPU_RES_PERF_CNT_EN.
module fpu_res_pack
  import fpu_defs::*;
#(
  parameter int unsigned C_EXP   = 8,
  parameter int unsigned C_MANT  = 23,
  parameter int unsigned C_CMD   = 4,
  parameter int unsigned C_DEPTH = 2
) (
  input  logic              Clk_CI,
  input  logic              Rst_RI,
  input  logic              In_valid_SI,
  output logic              In_ready_SO,
  input  logic [C_CMD-1:0]  Op_SI,
  input  logic              Sign_res_DI,
  input  logic [C_EXP-1:0]  Exp_res_DI,
  input  logic [C_MANT:0]   Mant_norm_DI,
  input  logic [31:0]       Int_res_DI,
  input  logic              Exp_toZero_SI,
  input  logic              Exp_toInf_SI,
  input  logic              Mant_toZero_SI,
  input  logic              IV_SI,
  input  logic              OF_SI,
  input  logic              UF_SI,
  input  logic              IX_SI,
  input  logic              Zero_SI,
  input  logic              Inf_SI,
  input  logic              Flush_SI,
  input  logic              Fflags_clr_SI,
  output logic              Out_valid_SO,
  input  logic              Out_ready_SI,
  output logic [31:0]       Res_DO,
  output logic [4:0]        Flags_DO,
  output logic              Zero_SO,
  output logic              Inf_SO,
  output logic [4:0]        Fflags_DO,
  output logic [31:0]       Perf_cnt_DO
);

  logic [1:0]        w_count;
  logic              w_push;
  logic              w_pop;
  logic [C_EXP-1:0]  w_exp;
  logic [C_MANT-1:0] w_mant;
  res_entry_t        w_in;
  res_entry_t        w_head;
  logic [4:0]        r_fflags;
  logic              w_unused_hidden;

  assign w_unused_hidden = Mant_norm_DI[C_MANT];

  assign In_ready_SO  = (w_count < 2'(C_DEPTH)) & ~Flush_SI;
  assign Out_valid_SO = (w_count != 2'd0);
  assign w_push       = In_valid_SI & In_ready_SO;
  assign w_pop        = Out_valid_SO & Out_ready_SI;

  // Overflow-to-infinity takes precedence over flush-to-zero.
  assign w_exp  = Exp_toInf_SI  ? C_EXP'(C_EXP_INF)  :
                  Exp_toZero_SI ? C_EXP'(C_EXP_ZERO) : Exp_res_DI;
  assign w_mant = Mant_toZero_SI ? C_MANT'(C_MANT_ZERO) : Mant_norm_DI[C_MANT-1:0];

  always_comb begin
    w_in       = '0;
    w_in.flags = {IV_SI, 1'b0, OF_SI, UF_SI, IX_SI};
    w_in.zero  = Zero_SI;
    w_in.inf   = Inf_SI;
    if (Op_SI == C_CMD'(C_FPU_F2I_CMD)) begin
      w_in.res = Int_res_DI;
    end else if (IV_SI) begin
      w_in.res = C_QNAN;
    end else begin
      w_in.res = {Sign_res_DI, w_exp, w_mant};
    end
  end

  fpu_res_fifo u_fifo (
    .i_clk   (Clk_CI),
    .i_rst   (Rst_RI),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (Flush_SI),
    .i_data  (w_in),
    .o_data  (w_head),
    .o_count (w_count)
  );

  assign Res_DO   = Out_valid_SO ? w_head.res   : 32'h0;
  assign Flags_DO = Out_valid_SO ? w_head.flags : 5'h0;
  assign Zero_SO  = Out_valid_SO & w_head.zero;
  assign Inf_SO   = Out_valid_SO & w_head.inf;

  // A pop that coincides with a flush does not commit its flags.
  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      r_fflags <= 5'h0;
    end else if (w_pop && !Flush_SI) begin
      r_fflags <= (Fflags_clr_SI ? 5'h0 : r_fflags) | w_head.flags;
    end else if (Fflags_clr_SI) begin
      r_fflags <= 5'h0;
    end
  end

  assign Fflags_DO = r_fflags;

`ifdef FPU_RES_PERF_CNT_EN
  logic [31:0] r_perf_cnt;

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      r_perf_cnt <= 32'h0;
    end else if (w_pop && (w_head.flags != 5'h0)) begin
      r_perf_cnt <= r_perf_cnt + 32'd1;
    end
  end

  assign Perf_cnt_DO = r_perf_cnt;
`else
  assign Perf_cnt_DO = 32'h0;
`endif

endmodule

// File: tb/tb_fpu_res_pack.sv
// Bench for fpu_res_pack: directed cases then random traffic against a queue model.
module tb_fpu_res_pack;
  import fpu_defs::*;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, sign, etz, eti, mtz;
  logic        iv, of_f, uf, ix, zero_i, inf_i, flush, clr, out_valid, out_ready;
  logic [3:0]  op;
  logic [7:0]  exp_r;
  logic [23:0] mant;
  logic [31:0] int_res, res, perf;
  logic [4:0]  flags, fflags;
  logic        zero_o, inf_o;

  always #5 clk = ~clk;

  fpu_res_pack dut (
    .Clk_CI        (clk),
    .Rst_RI        (rst),
    .In_valid_SI   (in_valid),
    .In_ready_SO   (in_ready),
    .Op_SI         (op),
    .Sign_res_DI   (sign),
    .Exp_res_DI    (exp_r),
    .Mant_norm_DI  (mant),
    .Int_res_DI    (int_res),
    .Exp_toZero_SI (etz),
    .Exp_toInf_SI  (eti),
    .Mant_toZero_SI(mtz),
    .IV_SI         (iv),
    .OF_SI         (of_f),
    .UF_SI         (uf),
    .IX_SI         (ix),
    .Zero_SI       (zero_i),
    .Inf_SI        (inf_i),
    .Flush_SI      (flush),
    .Fflags_clr_SI (clr),
    .Out_valid_SO  (out_valid),
    .Out_ready_SI  (out_ready),
    .Res_DO        (res),
    .Flags_DO      (flags),
    .Zero_SO       (zero_o),
    .Inf_SO        (inf_o),
    .Fflags_DO     (fflags),
    .Perf_cnt_DO   (perf)
  );

  typedef struct {
    logic [31:0] res;
    logic [4:0]  fl;
    logic        z;
    logic        i;
  } m_t;

  m_t          mq[$];
  logic [4:0]  m_ff;
  int unsigned m_perf;
  int          n_chk = 0;
  int          n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_chk++;
    if (obs !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, want);
    end
  endtask

  // Reference result built arithmetically from the field rules.
  function automatic m_t model_entry();
    m_t          e;
    int unsigned ex, mn;
    e.fl = 5'((iv ? 16 : 0) + (of_f ? 4 : 0) + (uf ? 2 : 0) + (ix ? 1 : 0));
    e.z  = zero_i;
    e.i  = inf_i;
    if (op == C_FPU_F2I_CMD) e.res = int_res;
    else if (iv) e.res = 32'h7FC0_0000;
    else begin
      ex = eti ? 255 : (etz ? 0 : int'(exp_r));
      mn = mtz ? 0 : (int'(mant) % (1 << 23));
      e.res = (sign ? 32'h8000_0000 : 32'h0) + ex * (1 << 23) + mn;
    end
    return e;
  endfunction

  task automatic idle();
    rst = 0; in_valid = 0; out_ready = 0; flush = 0; clr = 0; op = C_FPU_ADD_CMD;
    sign = 0; exp_r = 0; mant = 0; int_res = 0; etz = 0; eti = 0; mtz = 0;
    iv = 0; of_f = 0; uf = 0; ix = 0; zero_i = 0; inf_i = 0;
  endtask

  task automatic check_outputs();
    check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      check("res", res, mq[0].res);
      check("flags", 32'(flags), 32'(mq[0].fl));
      check("zero", 32'(zero_o), 32'(mq[0].z));
      check("inf", 32'(inf_o), 32'(mq[0].i));
    end
    check("fflags", 32'(fflags), 32'(m_ff));
`ifdef FPU_RES_PERF_CNT_EN
    check("perf", perf, m_perf);
`else
    check("perf", perf, 32'h0);
`endif
  endtask

  // Called at a negedge with inputs already set; advances one clock and checks.
  task automatic step();
    bit push, pop;
    m_t h;
    #1;
    check("in_ready", 32'(in_ready), 32'(mq.size() < 2 && !flush));
    push = in_valid && mq.size() < 2 && !flush;
    pop  = mq.size() != 0 && out_ready;
    if (rst) begin
      mq.delete(); m_ff = 0; m_perf = 0;
    end else begin
      if (pop) begin
        h = mq[0];
        if (h.fl != 0) m_perf++;
        if (!flush) begin
          m_ff = (clr ? 5'h0 : m_ff) | h.fl;
          void'(mq.pop_front());
        end else if (clr) m_ff = 0;
      end else if (clr) m_ff = 0;
      if (flush) mq.delete();
      else if (push) mq.push_back(model_entry());
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic pop_one();
    idle(); out_ready = 1; step();
  endtask

  initial begin
    idle();
    mq.delete(); m_ff = 0; m_perf = 0;
    @(negedge clk);
    rst = 1; step(); step();
    check("rst_res", res, 32'h0);
    check("rst_ready", 32'(in_ready), 32'h1);

    // ADD 3.0 inexact
    idle(); in_valid = 1; exp_r = 8'h80; mant = 24'hC00000; ix = 1; step();
    check("add_res", res, 32'h4040_0000);
    check("add_flags", 32'(flags), 32'h01);
    pop_one();
    check("add_fflags", 32'(fflags), 32'h01);

    idle(); in_valid = 1; op = C_FPU_MUL_CMD; iv = 1; eti = 1; exp_r = 8'h12; step();
    check("nan_res", res, 32'h7FC0_0000);
    check("nan_flags", 32'(flags), 32'h10);
    pop_one();
    idle(); in_valid = 1; of_f = 1; ix = 1; eti = 1; mtz = 1; sign = 1; mant = 24'hABCDEF; step();
    check("ovf_res", res, 32'hFF80_0000);
    check("ovf_flags", 32'(flags), 32'h05);
    pop_one();

    idle(); in_valid = 1; op = C_FPU_F2I_CMD; int_res = 32'h8000_0000; iv = 1; step();
    check("f2i_res", res, 32'h8000_0000);
    check("f2i_flags", 32'(flags), 32'h10);
    pop_one();

    // Backpressure: fill, stall third push, drain in order
    idle(); in_valid = 1; exp_r = 8'h01; step();
    idle(); in_valid = 1; exp_r = 8'h02; step();
    check("full_ready", 32'(in_ready), 32'h0);
    idle(); in_valid = 1; exp_r = 8'h03; step();
    check("held_head", res, 32'h0080_0000);
    pop_one();
    check("second", res, 32'h0100_0000);
    pop_one();
    check("drained", 32'(out_valid), 32'h0);
    check("ready_back", 32'(in_ready), 32'h1);

    // Clear coinciding with a pop leaves only the popped flags
    idle(); clr = 1; step();
    idle(); in_valid = 1; ix = 1; step();
    pop_one();
    idle(); in_valid = 1; of_f = 1; step();
    idle(); out_ready = 1; clr = 1; step();
    check("clr_pop", 32'(fflags), 32'h04);

    idle(); in_valid = 1; step();
    idle(); in_valid = 1; uf = 1; step();
    idle(); flush = 1; in_valid = 1; step();
    check("flush_valid", 32'(out_valid), 32'h0);
    check("flush_ff", 32'(fflags), 32'h04);

    idle(); in_valid = 1; ix = 1; step();
    idle(); rst = 1; in_valid = 1; out_ready = 1; step();
    check("rst_mid", 32'(out_valid), 32'h0);
    check("rst_ff", 32'(fflags), 32'h0);

    // Exception-op counter: flags 01, 00, 10
    idle(); in_valid = 1; ix = 1; step(); pop_one();
    idle(); in_valid = 1; step(); pop_one();
    idle(); in_valid = 1; iv = 1; step(); pop_one();
`ifdef FPU_RES_PERF_CNT_EN
    check("perf_cnt", perf, 32'd2);
`else
    check("perf_cnt", perf, 32'd0);
`endif

    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 99) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 1) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      clr       = ($urandom_range(0, 7) == 0);
      op        = 4'($urandom_range(0, 4));
      sign      = 1'($urandom);
      exp_r     = 8'($urandom);
      mant      = 24'($urandom) | 24'h80_0000;
      int_res   = $urandom;
      etz       = ($urandom_range(0, 5) == 0);
      eti       = ($urandom_range(0, 5) == 0);
      mtz       = ($urandom_range(0, 5) == 0);
      iv        = ($urandom_range(0, 5) == 0);
      of_f      = ($urandom_range(0, 5) == 0);
      uf        = ($urandom_range(0, 5) == 0);
      ix        = ($urandom_range(0, 2) == 0);
      zero_i    = 1'($urandom);
      inf_i     = 1'($urandom);
      step();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/fpu_res_pack.md
Name: fpu_res_pack

Overview:
- Stage directly downstream of the FPU exception stage.
- Takes the normalised sign/exponent/mantissa and the exception stage's manipulation controls, and assembles the final 32-bit IEEE result word (or passes the integer result through for F2I).
- Buffers results in a 2-entry output queue with a valid/ready handshake.
- Maintains the architectural sticky exception flags (fflags) as results are committed to the core.

Parameters:
- C_EXP, 8, exponent width
- C_MANT, 23, stored mantissa width (hidden bit excluded)
- C_CMD, 4, operation code width
- C_DEPTH, 2, output queue depth (only 2 supported)

Ports:
- Clk_CI  in  1  clock
- Rst_RI  in  1  synchronous active-high reset
- In_valid_SI  in  1  input result valid
- In_ready_SO  out  1  stage can accept input
- Op_SI  in  C_CMD  operation code
- Sign_res_DI  in  1  result sign
- Exp_res_DI  in  C_EXP  rounded exponent
- Mant_norm_DI  in  C_MANT+1  normalised mantissa, hidden bit at MSB
- Int_res_DI  in  32  F2I integer result
- Exp_toZero_SI / Exp_toInf_SI / Mant_toZero_SI  in  1 each  manipulation controls from the exception stage
- IV_SI / OF_SI / UF_SI / IX_SI / Zero_SI / Inf_SI  in  1 each  exception and status flags
- Flush_SI  in  1  discard all queued results
- Fflags_clr_SI  in  1  clear sticky flags
- Out_valid_SO  out  1  result available
- Out_ready_SI  in  1  consumer accepts result
- Res_DO  out  32  result word
- Flags_DO  out  5  per-op flags {NV,DZ,OF,UF,NX}
- Zero_SO / Inf_SO  out  1 each  per-op status
- Fflags_DO  out  5  sticky flags
- Perf_cnt_DO  out  32  exception op count (macro only)

Behaviour:
- Reset (Rst_RI high at clock edge):
  - queue empty; Out_valid_SO=0; In_ready_SO=1.
  - Res_DO=0, Flags_DO=0, Zero_SO=0, Inf_SO=0, Fflags_DO=0, Perf_cnt_DO=0.
  - Reset has priority over every other input. Reset mid-transfer drops all queued entries.
- Assembly (combinational, at push):
  - Op_SI==C_FPU_F2I_CMD: Res = Int_res_DI.
  - Else if IV_SI: Res = 32'h7FC0_0000 (canonical qNaN, sign forced 0).
  - Else: sign = Sign_res_DI.
  - Exponent = C_EXP_INF if Exp_toInf_SI; else C_EXP_ZERO if Exp_toZero_SI; else Exp_res_DI. Exp_toInf_SI wins over Exp_toZero_SI.
  - Mantissa = 0 if Mant_toZero_SI, else Mant_norm_DI[C_MANT-1:0].
  - Flags = {IV_SI, 1'b0, OF_SI, UF_SI, IX_SI}. DZ is always 0 (no divider).
- Queue:
  - Push when In_valid_SI & In_ready_SO.
  - Pop when Out_valid_SO & Out_ready_SI.
  - In_ready_SO = (count<2) & ~Flush_SI. It is registered-count based, with no combinational path from Out_ready_SI.
  - Latency: 1 cycle, push edge to Out_valid_SO.
  - Out_valid_SO = count!=0. Outputs show the head entry and stay stable while valid & ~ready.
  - Push and pop in the same cycle at count 1: count stays 1, new entry becomes head.
  - At count 2, push is impossible.
  - Pop at count 0 is ignored.
- Flush_SI: next cycle count=0. A push in the same cycle is dropped. Fflags are unchanged, and a pop in the same cycle does not update fflags.
- Fflags:
  - On pop: Fflags_q <= (Fflags_clr_SI ? 0 : Fflags_q) | head Flags.
  - Clear without pop: Fflags_q <= 0.
  - Clear and pop in the same cycle leaves exactly the popped op's flags.

Optional Feature:
- Macro: FPU_RES_PERF_CNT_EN
- Defined: Perf_cnt_DO increments by 1 on each pop whose Flags!=0. It wraps 0xFFFF_FFFF→0, clears on reset only, and is unaffected by Flush_SI and Fflags_clr_SI.
- Undefined: no counter logic; Perf_cnt_DO tied to 0.

Decomposition:
- fpu_defs package: C_EXP_INF, C_EXP_ZERO, C_MANT_ZERO, C_QNAN (32'h7FC0_0000), the op codes, and the flag bit indices (C_FFLAG_NV=4 … C_FFLAG_NX=0).
- Package also holds typedef res_entry_t: {res[31:0], flags[4:0], zero, inf}.
- One sub-module, fpu_res_fifo: 2-entry queue of res_entry_t with push/pop/flush/count.

Test Plan:
- ADD, Sign=0, Exp=0x80, Mant_norm=0xC00000, all controls 0, IX=1 → after 1 cycle Res=0x40400000, Flags=0x01; on pop Fflags=0x01.
- MUL with IV=1 and Exp_toInf=1 → Res=0x7FC00000, Flags=0x10; ADD with OF=1, IX=1, Exp_toInf=1, Mant_toZero=1, Sign=1 → Res=0xFF800000, Flags=0x05.
- F2I, Int_res=0x8000_0000, IV=1 → Res=0x80000000, Flags=0x10.
- Out_ready=0, push 2 ops → In_ready=0 and third push stalled; head held stable; then ready=1 → two pops in order, then In_ready=1.
- Fflags=0x01 with Fflags_clr and a pop of a Flags=0x04 op in the same cycle → Fflags=0x04. Flush with 2 entries → Out_valid=0 next cycle, Fflags unchanged.
- Rst_RI asserted with 1 entry queued → next cycle all outputs 0, In_ready=1. With FPU_RES_PERF_CNT_EN defined, 3 pops with flags {0x01,0x00,0x10} → Perf_cnt=2.
